// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions PS2_CLK/PS2_DATA, deframes 11-bit scan-code set 2
// frames, folds E0/F0 prefixes into one key event and decodes the tic-tac-toe game keys.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CCLK,
    input  logic       BTN0,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_BREAK,
    output logic       KEY_VALID,
    output logic       KEY_UP,
    output logic       KEY_DOWN,
    output logic       KEY_LEFT,
    output logic       KEY_RIGHT,
    output logic       KEY_ENTER,
    output logic       KEY_X,
    output logic       KEY_O,
    output logic       FRAME_ERR
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic clk_s1_q;
    logic clk_s2_q;
    logic dat_s1_q;
    logic dat_s2_q;

    always_ff @(posedge CCLK) begin
        // NOTE: sequential state is always written with <=, so every flop samples
        // pre-edge values and the order of always_ff blocks never matters.
        if (BTN0) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DATA;
            dat_s2_q <= dat_s1_q;
        end
    end

    logic [FLT_W-1:0] flt_cnt_q;
    logic [FLT_W-1:0] flt_cnt_d;
    logic             flt_q;
    logic             flt_d;
    logic             fall_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path can leave it unassigned and infer a latch.
        flt_cnt_d = '0;
        flt_d     = flt_q;
        if (clk_s2_q != flt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge CCLK) begin
        if (BTN0) begin
            flt_cnt_q <= '0;
            flt_q     <= 1'b1;
            fall_q    <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            flt_q     <= flt_d;
            fall_q    <= flt_q & ~flt_d;
        end
    end

    // ------------------------------------------------------------------
    // Game-key decode (make events only; caller masks breaks)
    // ------------------------------------------------------------------
    function automatic logic [6:0] game_decode(input logic ext, input logic [7:0] code);
        logic [6:0] g;
        g = '0;
        case ({ext, code})
            {1'b1, 8'h75}: g = 7'b1000000;
            {1'b1, 8'h72}: g = 7'b0100000;
            {1'b1, 8'h6B}: g = 7'b0010000;
            {1'b1, 8'h74}: g = 7'b0001000;
            {1'b0, 8'h5A}: g = 7'b0000100;
            {1'b0, 8'h22}: g = 7'b0000010;
            {1'b0, 8'h44}: g = 7'b0000001;
            default:       g = '0;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Frame FSM, timeout and byte handler
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [2:0]       bitcnt_q;
    logic [2:0]       bitcnt_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             parity_q;
    logic             parity_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             ext_q;
    logic             ext_d;
    logic             brk_q;
    logic             brk_d;
    logic [7:0]       code_q;
    logic [7:0]       code_d;
    logic             key_ext_q;
    logic             key_ext_d;
    logic             key_brk_q;
    logic             key_brk_d;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;
    logic [6:0]       game_q;
    logic [6:0]       game_d;
    logic             good_byte;
    logic             timeout;

    assign timeout = (state_q != S_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        code_d    = code_q;
        key_ext_d = key_ext_q;
        key_brk_d = key_brk_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        game_d    = '0;
        good_byte = 1'b0;

        if (timeout) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
            bitcnt_d = '0;
            shift_d  = '0;
        end else if (fall_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2_q && ((^shift_q) ^ parity_q)) begin
                        good_byte = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Prefix bytes only arm flags; any other byte closes the event.
        if (good_byte) begin
            if (shift_q == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == CODE_BRK) begin
                brk_d = 1'b1;
            end else begin
                code_d    = shift_q;
                key_ext_d = ext_q;
                key_brk_d = brk_q;
                valid_d   = 1'b1;
                game_d    = brk_q ? 7'b0 : game_decode(ext_q, shift_q);
                ext_d     = 1'b0;
                brk_d     = 1'b0;
            end
        end

        // Counter is 1 in the cycle after a fall, so it equals the number of cycles since it.
        if (state_d == S_IDLE) begin
            tmo_cnt_d = '0;
        end else if (fall_q) begin
            tmo_cnt_d = TMO_W'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge CCLK) begin
        if (BTN0) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_cnt_q <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            code_q    <= '0;
            key_ext_q <= 1'b0;
            key_brk_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            game_q    <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_cnt_q <= tmo_cnt_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            code_q    <= code_d;
            key_ext_q <= key_ext_d;
            key_brk_q <= key_brk_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            game_q    <= game_d;
        end
    end

    assign KEY_CODE  = code_q;
    assign KEY_EXT   = key_ext_q;
    assign KEY_BREAK = key_brk_q;
    assign KEY_VALID = valid_q;
    assign KEY_UP    = game_q[6];
    assign KEY_DOWN  = game_q[5];
    assign KEY_LEFT  = game_q[4];
    assign KEY_RIGHT = game_q[3];
    assign KEY_ENTER = game_q[2];
    assign KEY_X     = game_q[1];
    assign KEY_O     = game_q[0];
    assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed frame table, timeout/glitch/reset sequences and
// randomized frames checked against a byte-level event model.
module tb_ps2_keyboard_rx;

    localparam int FL   = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    localparam logic [6:0] G_NONE  = 7'b0000000;
    localparam logic [6:0] G_UP    = 7'b1000000;
    localparam logic [6:0] G_DOWN  = 7'b0100000;
    localparam logic [6:0] G_LEFT  = 7'b0010000;
    localparam logic [6:0] G_RIGHT = 7'b0001000;
    localparam logic [6:0] G_ENTER = 7'b0000100;
    localparam logic [6:0] G_X     = 7'b0000010;
    localparam logic [6:0] G_O     = 7'b0000001;

    typedef struct packed {
        logic       err;
        logic       valid;
        logic       ext;
        logic       brk;
        logic [6:0] game;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         bad_start;
        bit         glitch;
        bit         has_evt;
        ev_t        exp;
    } row_t;

    logic       CCLK = 1'b0;
    logic       BTN0 = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT, KEY_BREAK, KEY_VALID;
    logic       KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ENTER, KEY_X, KEY_O;
    logic       FRAME_ERR;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .CCLK(CCLK), .BTN0(BTN0), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .KEY_CODE(KEY_CODE), .KEY_EXT(KEY_EXT), .KEY_BREAK(KEY_BREAK), .KEY_VALID(KEY_VALID),
        .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN), .KEY_LEFT(KEY_LEFT), .KEY_RIGHT(KEY_RIGHT),
        .KEY_ENTER(KEY_ENTER), .KEY_X(KEY_X), .KEY_O(KEY_O), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CCLK = ~CCLK;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_fall_cyc = 0;
    ev_t  obs_q[$];
    int   obs_cyc[$];
    ev_t  exp_q[$];
    row_t tbl[$];

    // Model state: armed prefixes and the held output registers.
    logic       m_ext, m_brk, m_kext, m_kbrk;
    logic [7:0] m_code;

    always @(posedge CCLK) cyc <= cyc + 1;

    function automatic ev_t mk(input logic err, input logic valid, input logic ext,
                               input logic brk, input logic [6:0] game, input logic [7:0] code);
        ev_t e;
        e.err   = err;
        e.valid = valid;
        e.ext   = ext;
        e.brk   = brk;
        e.game  = game;
        e.code  = code;
        return e;
    endfunction

    always @(negedge CCLK) begin
        if (FRAME_ERR || KEY_VALID || KEY_UP || KEY_DOWN || KEY_LEFT || KEY_RIGHT ||
            KEY_ENTER || KEY_X || KEY_O) begin
            obs_q.push_back(mk(FRAME_ERR, KEY_VALID, KEY_EXT, KEY_BREAK,
                               {KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ENTER, KEY_X, KEY_O},
                               KEY_CODE));
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%h req=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({KEY_CODE, KEY_EXT, KEY_BREAK, KEY_VALID, KEY_UP, KEY_DOWN, KEY_LEFT,
                    KEY_RIGHT, KEY_ENTER, KEY_X, KEY_O, FRAME_ERR});
    endfunction

    function automatic logic [6:0] game_of(input logic ext, input logic brk, input logic [7:0] c);
        if (brk) return G_NONE;
        if (ext) begin
            case (c)
                8'h75:   return G_UP;
                8'h72:   return G_DOWN;
                8'h6B:   return G_LEFT;
                8'h74:   return G_RIGHT;
                default: return G_NONE;
            endcase
        end
        case (c)
            8'h5A:   return G_ENTER;
            8'h22:   return G_X;
            8'h44:   return G_O;
            default: return G_NONE;
        endcase
    endfunction

    task automatic model_reset();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_kext = 1'b0;
        m_kbrk = 1'b0;
        m_code = 8'h00;
    endtask

    // good=0 is a bad frame or timeout; bad_start errors without touching prefixes.
    task automatic model_step(input logic [7:0] b, input bit good, input bit bad_start);
        if (bad_start) begin
            exp_q.push_back(mk(1'b1, 1'b0, m_kext, m_kbrk, G_NONE, m_code));
        end else if (!good) begin
            exp_q.push_back(mk(1'b1, 1'b0, m_kext, m_kbrk, G_NONE, m_code));
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_code = b;
            m_kext = m_ext;
            m_kbrk = m_brk;
            exp_q.push_back(mk(1'b0, 1'b1, m_ext, m_brk, game_of(m_ext, m_brk, b), b));
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        PS2_DATA = b;
        if (glitch) begin
            tick(4);
            PS2_CLK = 1'b0;
            tick(FL - 2);
            PS2_CLK = 1'b1;
            tick(14);
        end else begin
            tick(HALF);
        end
        PS2_CLK = 1'b0;
        last_fall_cyc = cyc;
        tick(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        logic par;
        par = ~(^b) ^ bad_par;
        clear_obs();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i == 4));
        ps2_bit(par, 1'b0);
        ps2_bit(!bad_stop, 1'b0);
        PS2_DATA = 1'b1;
        tick(6);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic add_row(input logic [7:0] d, input bit bp, input bit bs, input bit bst,
                           input bit gl, input bit has, input ev_t e);
        row_t r;
        r.data = d; r.bad_par = bp; r.bad_stop = bs; r.bad_start = bst;
        r.glitch = gl; r.has_evt = has; r.exp = e;
        tbl.push_back(r);
    endtask

    initial begin
        logic [31:0] hold;
        int          lat;
        int          waited;
        logic [7:0]  b;
        bit          bp, bs, gl;
        int          r;
        logic [7:0]  game_codes [7];

        game_codes[0] = 8'h75; game_codes[1] = 8'h72; game_codes[2] = 8'h6B;
        game_codes[3] = 8'h74; game_codes[4] = 8'h5A; game_codes[5] = 8'h22;
        game_codes[6] = 8'h44;

        //       data   bp bs bst gl has  expected {err,valid,ext,brk,game,code}
        add_row(8'h22, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, G_X,     8'h22));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h75, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, G_UP,    8'h75));
        add_row(8'h5A, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, G_ENTER, 8'h5A));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'hF0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h75, 0, 0, 0, 0, 1, mk(0, 1, 1, 1, G_NONE,  8'h75));
        add_row(8'hF0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h5A, 1, 0, 0, 0, 1, mk(1, 0, 1, 1, G_NONE,  8'h75));
        add_row(8'h5A, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, G_ENTER, 8'h5A));
        add_row(8'h75, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, G_NONE,  8'h75));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h5A, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, G_NONE,  8'h5A));
        add_row(8'h44, 0, 0, 0, 1, 1, mk(0, 1, 0, 0, G_O,     8'h44));
        add_row(8'h00, 0, 0, 1, 0, 1, mk(1, 0, 0, 0, G_NONE,  8'h44));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h72, 0, 1, 0, 0, 1, mk(1, 0, 0, 0, G_NONE,  8'h44));
        add_row(8'h6B, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, G_NONE,  8'h6B));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h6B, 0, 0, 0, 1, 1, mk(0, 1, 1, 0, G_LEFT,  8'h6B));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h74, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, G_RIGHT, 8'h74));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h72, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, G_DOWN,  8'h72));
        add_row(8'hE1, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, G_NONE,  8'hE1));
        add_row(8'hE0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, G_NONE,  8'h00));
        add_row(8'h22, 0, 0, 0, 0, 1, mk(0, 1, 1, 0, G_NONE,  8'h22));

        BTN0 = 1'b1;
        tick(4);
        check("reset_outs", all_outs(), 32'h0);
        BTN0 = 1'b0;
        tick(5);
        check("post_reset_outs", all_outs(), 32'h0);
        model_reset();
        hold = 32'h0;
        lat = 11;

        foreach (tbl[i]) begin
            if (tbl[i].bad_start) begin
                clear_obs();
                ps2_bit(1'b1, 1'b0);
                tick(6);
            end else begin
                send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop, tbl[i].glitch);
            end
            model_step(tbl[i].data, !(tbl[i].bad_par || tbl[i].bad_stop), tbl[i].bad_start);
            exp_q.delete();
            if (tbl[i].has_evt) begin
                exp_q.push_back(tbl[i].exp);
                hold = 32'({tbl[i].exp.code, tbl[i].exp.ext, tbl[i].exp.brk});
            end
            if (i == 0 && obs_q.size() > 0) begin
                lat = obs_cyc[0] - last_fall_cyc;
                check("strobe_latency_window", 32'(lat >= 11 && lat <= 13), 32'h1);
            end
            compare_events($sformatf("row%0d", i));
            check($sformatf("row%0d_hold", i), 32'({KEY_CODE, KEY_EXT, KEY_BREAK}), hold);
        end

        // Timeout: start plus 4 data bits, then the clock stays high.
        clear_obs();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        PS2_DATA = 1'b1;
        waited = 0;
        while (obs_q.size() == 0 && waited < TMO + 100) begin
            tick(1);
            waited++;
        end
        if (obs_q.size() > 0) check("timeout_latency", obs_cyc[0] - last_fall_cyc, lat + TMO);
        else check("timeout_seen", 32'h0, 32'h1);
        tick(20);
        model_step(8'h00, 1'b0, 1'b0);
        compare_events("timeout");
        send_frame(8'h44, 1'b0, 1'b0, 1'b0);
        model_step(8'h44, 1'b1, 1'b0);
        compare_events("after_timeout");

        // Reset mid-frame after data bit 3.
        clear_obs();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        BTN0 = 1'b1;
        tick(1);
        check("mid_reset_outs", all_outs(), 32'h0);
        tick(2);
        BTN0 = 1'b0;
        tick(10);
        check("after_reset_outs", all_outs(), 32'h0);
        check("after_reset_no_evt", obs_q.size(), 32'h0);
        model_reset();
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        model_step(8'h22, 1'b1, 1'b0);
        compare_events("after_reset_frame");

        // Randomized frames against the event model.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r <= 5) b = game_codes[$urandom_range(0, 6)];
            else b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 15) == 0);
            gl = ($urandom_range(0, 3) == 0);
            send_frame(b, bp, bs, gl);
            model_step(b, !(bp || bs), 1'b0);
            compare_events($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_hold", k), 32'({KEY_CODE, KEY_EXT, KEY_BREAK}),
                  32'({m_code, m_kext, m_kbrk}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
